jzjpcc_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It sits directly downstream of the ALU operand mux and consumes the same `aluOperandA`/`aluOperandB` operands, with bypassing already applied. It performs one M-extension operation at a time using a radix-2 shift-add/shift-subtract datapath. It stalls the pipeline through the hazard unit until the result is ready.

---
 rtl/jzjpcc_muldiv.sv | 224 ++++++++++++++++++++++
 tb/tb_jzjpcc_muldiv.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : jzjpcc_muldiv
// Purpose  : Iterative RV32M multiply/divide unit for the execute stage.
//            A radix-2 shift-add multiplier and a restoring divider share one
//            64-bit accumulator. Each operation takes 32 iteration cycles plus
//            one sign-fix cycle. The divide-by-zero and signed-overflow cases
//            skip the iterations and complete in one cycle.
// Ports    : clock    - rising-edge clock
//            reset    - asynchronous active-low reset
//            start    - M-extension op present in execute (sampled in IDLE)
//            funct3   - RV32M operation select
//            operandA - rs1 (multiplicand / dividend)
//            operandB - rs2 (multiplier / divisor)
//            flush    - synchronous abort of the current operation
//            busy     - combinational stall request to the hazard unit
//            done     - one-cycle pulse, result valid while high
//            result   - registered result
// Revision : 1.0 - initial release
// ============================================================================
module jzjpcc_muldiv (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [2:0] c_MUL    = 3'b000;
    localparam logic [2:0] c_MULH   = 3'b001;
    localparam logic [2:0] c_MULHSU = 3'b010;
    localparam logic [2:0] c_MULHU  = 3'b011;
    localparam logic [2:0] c_DIV    = 3'b100;
    localparam logic [2:0] c_DIVU   = 3'b101;
    localparam logic [2:0] c_REM    = 3'b110;
    localparam logic [2:0] c_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [2:0]  r_op;
    logic        r_neg_a;
    logic        r_neg_b;
    logic [4:0]  r_count;
    // Multiply: running product. Divide: {remainder, quotient/dividend}.
    logic [63:0] r_acc;
    // Multiplicand, shifted left one place per iteration.
    logic [63:0] r_mcand;
    // Multiply: multiplier shifted right per iteration. Divide: divisor.
    logic [31:0] r_opb;

    // ------------------------------------------------------------------------
    // Operand decode in IDLE
    // ------------------------------------------------------------------------
    logic        w_accept;
    logic        w_signed_a;
    logic        w_signed_b;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic        w_special;
    logic [31:0] w_special_res;

    assign w_accept   = (r_state == S_IDLE) && start && !flush;
    assign w_signed_a = (funct3 == c_DIV) || (funct3 == c_REM) ||
                        (funct3 == c_MULH) || (funct3 == c_MULHSU);
    assign w_signed_b = (funct3 == c_DIV) || (funct3 == c_REM) ||
                        (funct3 == c_MULH);
    assign w_neg_a    = w_signed_a && operandA[31];
    assign w_neg_b    = w_signed_b && operandB[31];
    // Magnitude of 0x80000000 is 0x80000000 when read as unsigned, which the
    // unsigned datapath handles directly.
    assign w_mag_a    = w_neg_a ? (~operandA + 32'd1) : operandA;
    assign w_mag_b    = w_neg_b ? (~operandB + 32'd1) : operandB;

    assign w_div_zero = funct3[2] && (operandB == 32'd0);
    assign w_div_ovf  = ((funct3 == c_DIV) || (funct3 == c_REM)) &&
                        (operandA == 32'h8000_0000) &&
                        (operandB == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero || w_div_ovf;

    // funct3[1] distinguishes remainder from quotient among divide ops.
    always_comb begin
        w_special_res = 32'd0;
        if (w_div_zero)
            w_special_res = funct3[1] ? operandA : 32'hFFFF_FFFF;
        else
            w_special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // ------------------------------------------------------------------------
    // Iteration step
    // ------------------------------------------------------------------------
    logic [32:0] w_trial;
    logic [32:0] w_diff;
    logic [63:0] w_div_next;
    logic [63:0] w_mul_next;

    // Shifted partial remainder keeps its carry-out bit so the compare is
    // exact for divisors at the top of the unsigned range.
    assign w_trial    = r_acc[63:31];
    assign w_diff     = w_trial - {1'b0, r_opb};
    assign w_div_next = !w_diff[32] ? {w_diff[31:0], r_acc[30:0], 1'b1}
                                    : {r_acc[62:0], 1'b0};
    assign w_mul_next = r_opb[0] ? (r_acc + r_mcand) : r_acc;

    // ------------------------------------------------------------------------
    // Sign correction and result selection
    // ------------------------------------------------------------------------
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_fix_res;

    assign w_prod = (r_neg_a ^ r_neg_b) ? (~r_acc + 64'd1) : r_acc;
    assign w_quot = (r_neg_a ^ r_neg_b) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem  = r_neg_a ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_comb begin
        w_fix_res = 32'd0;
        case (r_op)
            c_MUL:                      w_fix_res = w_prod[31:0];
            c_MULH, c_MULHSU, c_MULHU:  w_fix_res = w_prod[63:32];
            c_DIV, c_DIVU:              w_fix_res = w_quot;
            c_REM, c_REMU:              w_fix_res = w_rem;
            default:                    w_fix_res = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
            S_CALC: if (r_count == 5'd31) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush)
            w_next = S_IDLE;
    end

    assign busy = w_accept || (r_state == S_CALC) || (r_state == S_FIX);
    assign done = (r_state == S_DONE);

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op    <= 3'd0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_count <= 5'd0;
            r_acc   <= 64'd0;
            r_mcand <= 64'd0;
            r_opb   <= 32'd0;
            result  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= funct3;
                        r_neg_a <= w_neg_a;
                        r_neg_b <= w_neg_b;
                        r_count <= 5'd0;
                        r_opb   <= w_mag_b;
                        if (funct3[2]) begin
                            r_acc   <= {32'd0, w_mag_a};
                            r_mcand <= 64'd0;
                        end else begin
                            r_acc   <= 64'd0;
                            r_mcand <= {32'd0, w_mag_a};
                        end
                        if (w_special)
                            result <= w_special_res;
                    end
                end
                S_CALC: begin
                    r_count <= r_count + 5'd1;
                    if (r_op[2]) begin
                        r_acc <= w_div_next;
                    end else begin
                        r_acc   <= w_mul_next;
                        r_mcand <= {r_mcand[62:0], 1'b0};
                        r_opb   <= {1'b0, r_opb[31:1]};
                    end
                end
                S_FIX: begin
                    if (!flush)
                        result <= w_fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jzjpcc_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_jzjpcc_muldiv
// Purpose  : Self-checking bench for jzjpcc_muldiv: table of directed RV32M
//            vectors with hand-computed results and latencies, plus flush,
//            start-with-flush and mid-operation reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jzjpcc_muldiv;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int failures;

    jzjpcc_muldiv dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .funct3   (funct3),
        .operandA (operandA),
        .operandB (operandB),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int c_NVEC = 21;
    vec_t tbl [c_NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one op and follows it to its done pulse. With wait_neg=0 the
    // inputs are driven immediately (caller is already away from the edge).
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input bit wait_neg,
                          input string tag);
        int lat;
        int bcnt;
        if (wait_neg) @(negedge clock);
        funct3   = f;
        operandA = a;
        operandB = b;
        start    = 1'b1;
        #1;
        check({tag, " busy_at_accept"}, {31'd0, busy}, 32'd1);
        @(posedge clock);
        #1;
        start    = 1'b0;
        operandA = 32'hDEAD_BEEF;
        operandB = 32'h0000_0000;
        funct3   = ~f;
        lat  = 1;
        bcnt = 1;
        while (!done && lat < 60) begin
            if (busy) bcnt++;
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp);
        check({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
        check({tag, " busy_cycles"}, 32'(bcnt), 32'(exp_lat));
        @(posedge clock);
        #1;
        check({tag, " done_pulse_width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int pulses;
        checks   = 0;
        failures = 0;

        //            f       a             b             expected      lat
        tbl[0]  = '{3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        tbl[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
        tbl[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
        tbl[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        tbl[4]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
        tbl[5]  = '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34};
        tbl[6]  = '{3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 34};
        tbl[7]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
        tbl[8]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
        tbl[9]  = '{3'b101, 32'd100,       32'd7,         32'd14,        34};
        tbl[10] = '{3'b111, 32'd100,       32'd7,         32'd2,         34};
        tbl[11] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        tbl[12] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         34};
        tbl[13] = '{3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         34};
        tbl[14] = '{3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34};
        tbl[15] = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        tbl[16] = '{3'b111, 32'd5,         32'd0,         32'd5,         1};
        tbl[17] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[18] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        tbl[19] = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        tbl[20] = '{3'b110, 32'd9,         32'd0,         32'd9,         1};

        reset    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        funct3   = 3'd0;
        operandA = 32'd0;
        operandB = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset done", {31'd0, done}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < c_NVEC; i++)
            run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 1'b1,
                   $sformatf("vec%0d", i));

        // start together with flush in IDLE must not be accepted
        @(negedge clock);
        funct3   = 3'b100;
        operandA = 32'd5;
        operandB = 32'd0;
        start    = 1'b1;
        flush    = 1'b1;
        #1;
        check("start_flush busy", {31'd0, busy}, 32'd0);
        @(posedge clock);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("start_flush no_done", {31'd0, done}, 32'd0);

        // flush during the 10th CALC cycle
        @(negedge clock);
        funct3   = 3'b000;
        operandA = 32'd5;
        operandB = 32'd6;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        flush = 1'b1;
        check("flush busy_before", {31'd0, busy}, 32'd1);
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush busy_after", {31'd0, busy}, 32'd0);
        check("flush done_after", {31'd0, done}, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) pulses++;
        end
        check("flush no_done_pulse", 32'(pulses), 32'd0);
        check("flush result_kept", result, 32'd9);
        run_op(3'b000, 32'd3, 32'd4, 32'd12, 34, 1'b1, "post_flush_mul");

        // asynchronous reset mid-CALC
        @(negedge clock);
        funct3   = 3'b101;
        operandA = 32'd100;
        operandB = 32'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset result", result, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b0, "post_reset_divu");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
